// File: rtl/mem_access_ctrl_if.sv
// Data-memory port bundle: req/ack handshake, word address, byte enables and data.
// The controller drives the request side; the memory returns the ack and the read word.
interface mem_if;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [3:0]  MemBE;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;

  modport master (
    output MemReq,
    output MemWe,
    output MemAddr,
    output MemBE,
    output MemWData,
    input  MemAck,
    input  MemRData
  );

  modport slave (
    input  MemReq,
    input  MemWe,
    input  MemAddr,
    input  MemBE,
    input  MemWData,
    output MemAck,
    output MemRData
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a variable-latency req/ack data memory.
// Stalls the pipeline while a transaction is outstanding and registers the result for WB.
module mem_access_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  LoadTypeM,
  input  logic [1:0]  StoreTypeM,
  input  logic [31:0] AddrM,
  input  logic [31:0] StoreDataM,
  mem_if.master       mem,
  output logic        StallReq,
  output logic [31:0] LoadDataW,
  output logic [1:0]  LoadedBytesSelectW,
  output logic [2:0]  LoadTypeW,
  output logic        MisalignErr,
  output logic        BusErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       lat_type;
  logic [1:0]       lat_off;

  logic        is_load;
  logic        is_store;
  logic        access;
  logic        half;
  logic        word;
  logic        misaligned;
  logic [3:0]  be_nxt;
  logic [31:0] wd_nxt;

  // A load present in the same cycle as a store takes precedence.
  always_comb begin
    is_load    = (LoadTypeM >= 3'd1) && (LoadTypeM <= 3'd5);
    is_store   = !is_load && (StoreTypeM != 2'd0);
    access     = is_load || is_store;
    half       = is_load ? ((LoadTypeM == 3'd2) || (LoadTypeM == 3'd5)) : (StoreTypeM == 2'd2);
    word       = is_load ? (LoadTypeM == 3'd3) : (StoreTypeM == 2'd3);
    misaligned = (half && AddrM[0]) || (word && (AddrM[1:0] != 2'b00));
    be_nxt     = 4'b1111;
    wd_nxt     = '0;
    if (is_store) begin
      case (StoreTypeM)
        2'd1: begin
          be_nxt = 4'b0001 << AddrM[1:0];
          wd_nxt = {4{StoreDataM[7:0]}};
        end
        2'd2: begin
          be_nxt = 4'b0011 << AddrM[1:0];
          wd_nxt = {2{StoreDataM[15:0]}};
        end
        default: begin
          be_nxt = 4'b1111;
          wd_nxt = StoreDataM;
        end
      endcase
    end
  end

  // Stall must fall the instant reset asserts, even with a valid access still on the inputs.
  assign StallReq = rst_n && ((state == REQ) ||
                              ((state == IDLE) && access && !misaligned));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      lat_type           <= '0;
      lat_off            <= '0;
      mem.MemReq         <= 1'b0;
      mem.MemWe          <= 1'b0;
      mem.MemAddr        <= '0;
      mem.MemBE          <= '0;
      mem.MemWData       <= '0;
      LoadDataW          <= '0;
      LoadedBytesSelectW <= '0;
      LoadTypeW          <= '0;
      MisalignErr        <= 1'b0;
      BusErr             <= 1'b0;
    end else begin
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              MisalignErr <= 1'b1;
              LoadTypeW   <= '0;
            end else begin
              mem.MemAddr  <= {AddrM[31:2], 2'b00};
              mem.MemWe    <= is_store;
              mem.MemBE    <= be_nxt;
              mem.MemWData <= wd_nxt;
              mem.MemReq   <= 1'b1;
              lat_off      <= AddrM[1:0];
              lat_type     <= is_load ? LoadTypeM : 3'd0;
              cnt          <= '0;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          // An ack arriving on the last allowed cycle still completes the access.
          if (mem.MemAck) begin
            if (lat_type != 3'd0) begin
              LoadDataW          <= mem.MemRData;
              LoadTypeW          <= lat_type;
              LoadedBytesSelectW <= lat_off;
            end else begin
              LoadTypeW <= '0;
            end
            mem.MemReq <= 1'b0;
            state      <= DONE;
          end else if (cnt == CNT_LAST) begin
            mem.MemReq <= 1'b0;
            BusErr     <= 1'b1;
            LoadDataW  <= '0;
            LoadTypeW  <= '0;
            state      <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          mem.MemReq <= 1'b0;
          cnt        <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level model of the MEM/WB contract.
// A scripted memory responder acks after a chosen number of REQ cycles, or never.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 64;
  localparam int NEVER   = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  LoadTypeM;
  logic [1:0]  StoreTypeM;
  logic [31:0] AddrM;
  logic [31:0] StoreDataM;
  logic        StallReq;
  logic [31:0] LoadDataW;
  logic [1:0]  LoadedBytesSelectW;
  logic [2:0]  LoadTypeW;
  logic        MisalignErr;
  logic        BusErr;

  mem_if mif ();

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .LoadTypeM          (LoadTypeM),
    .StoreTypeM         (StoreTypeM),
    .AddrM              (AddrM),
    .StoreDataM         (StoreDataM),
    .mem                (mif.master),
    .StallReq           (StallReq),
    .LoadDataW          (LoadDataW),
    .LoadedBytesSelectW (LoadedBytesSelectW),
    .LoadTypeW          (LoadTypeW),
    .MisalignErr        (MisalignErr),
    .BusErr             (BusErr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // WB-side state the model expects the controller to hold
  logic [31:0] m_ldata = '0;
  logic [1:0]  m_lsel  = '0;
  logic [2:0]  m_ltype = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag);
    check_eq({tag, "_ldata"}, LoadDataW, m_ldata);
    check_eq({tag, "_lsel"}, {30'd0, LoadedBytesSelectW}, {30'd0, m_lsel});
    check_eq({tag, "_ltype"}, {29'd0, LoadTypeW}, {29'd0, m_ltype});
  endtask

  // One MEM-stage instruction: drive it in an IDLE cycle and follow it to completion.
  task automatic do_access(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] addr,
                           input logic [31:0] sd, input int ack_dly, input logic [31:0] rd);
    bit          ld, sto, acc, mis, acked;
    int          sz, off, nreq, nstall, exp_req;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    ld  = (lt >= 3'd1) && (lt <= 3'd5);
    sto = !ld && (st != 2'd0);
    acc = ld || sto;
    if (ld) sz = (lt == 3'd1 || lt == 3'd4) ? 1 : (lt == 3'd2 || lt == 3'd5) ? 2 : 4;
    else    sz = (st == 2'd1) ? 1 : (st == 2'd2) ? 2 : 4;
    mis = acc && ((addr % sz) != 0);
    off = int'(addr[1:0]);
    ebe = 4'b0000;
    ewd = '0;
    for (int i = 0; i < 4; i++) begin
      if (ld || (i >= off && i < off + sz)) ebe[i] = 1'b1;
      ewd[8*i +: 8] = sd[8*(i % sz) +: 8];
    end

    @(negedge clk);
    LoadTypeM  = lt;
    StoreTypeM = st;
    AddrM      = addr;
    StoreDataM = sd;
    mif.MemAck   = acc ? 1'b0 : 1'($urandom_range(0, 1));
    mif.MemRData = $urandom;
    #1;
    check_eq("idle_req", mif.MemReq, 0);
    check_eq("idle_errs", {MisalignErr, BusErr}, 0);
    check_w("idle_hold");
    check_eq("idle_stall", StallReq, acc && !mis);
    if (!acc) return;

    if (mis) begin
      @(negedge clk);
      LoadTypeM  = 3'd0;
      StoreTypeM = 2'd0;
      #1;
      m_ltype = '0;
      check_eq("mis_pulse", MisalignErr, 1);
      check_eq("mis_noreq", mif.MemReq, 0);
      check_eq("mis_nostall", StallReq, 0);
      check_w("mis");
      return;
    end

    acked   = ack_dly < TIMEOUT;
    exp_req = acked ? ack_dly + 1 : TIMEOUT;
    nreq    = 0;
    nstall  = 1;
    for (int k = 0; k < TIMEOUT + 4; k++) begin
      @(negedge clk);
      mif.MemAck = 1'b0;
      #1;
      if (!mif.MemReq) break;
      nreq++;
      if (StallReq) nstall++;
      if (k == 0) begin
        check_eq("req_addr", mif.MemAddr, {addr[31:2], 2'b00});
        check_eq("req_we", mif.MemWe, sto);
        check_eq("req_be", {28'd0, mif.MemBE}, {28'd0, ebe});
        if (sto) check_eq("req_wdata", mif.MemWData, ewd);
      end
      if (k == ack_dly) begin
        mif.MemAck   = 1'b1;
        mif.MemRData = rd;
      end
    end
    check_eq("req_cycles", nreq, exp_req);
    check_eq("stall_cycles", nstall, exp_req + 1);

    if (acked) begin
      if (ld) begin
        m_ldata = rd;
        m_ltype = lt;
        m_lsel  = addr[1:0];
      end else begin
        m_ltype = '0;
      end
    end else begin
      m_ldata = '0;
      m_ltype = '0;
    end
    check_eq("done_stall", StallReq, 0);
    check_eq("done_buserr", BusErr, !acked);
    check_eq("done_mis", MisalignErr, 0);
    check_w("done");
  endtask

  initial begin
    int r, dly;
    logic [2:0] lt;
    rst_n      = 1'b0;
    LoadTypeM  = '0;
    StoreTypeM = '0;
    AddrM      = '0;
    StoreDataM = '0;
    mif.MemAck   = 1'b0;
    mif.MemRData = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req", mif.MemReq, 0);
    check_eq("rst_we", mif.MemWe, 0);
    check_eq("rst_addr", mif.MemAddr, 0);
    check_eq("rst_be", {28'd0, mif.MemBE}, 0);
    check_eq("rst_wdata", mif.MemWData, 0);
    check_eq("rst_stall", StallReq, 0);
    check_eq("rst_errs", {MisalignErr, BusErr}, 0);
    check_w("rst");
    @(negedge clk);
    rst_n = 1'b1;

    do_access(3'd3, 2'd0, 32'h0000_1000, 32'h0, 1, 32'hDEAD_BEEF);
    do_access(3'd0, 2'd1, 32'h0000_2003, 32'h0000_00A5, 0, 32'h0);
    do_access(3'd0, 2'd2, 32'h0000_2001, 32'h1234_5678, 0, 32'h0);
    do_access(3'd3, 2'd0, 32'h0000_2002, 32'h0, 0, 32'h0);
    do_access(3'd5, 2'd0, 32'h0000_3002, 32'h0, NEVER, 32'h0);
    do_access(3'd2, 2'd0, 32'h0000_3006, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);
    do_access(3'd1, 2'd3, 32'h0000_5001, 32'hFFFF_FFFF, 2, 32'h1122_3344);

    // Asynchronous reset in the middle of a load
    @(negedge clk);
    LoadTypeM  = 3'd1;
    StoreTypeM = 2'd0;
    AddrM      = 32'h0000_0020;
    #1;
    check_eq("ar_stall_idle", StallReq, 1);
    @(negedge clk);
    #1;
    check_eq("ar_req_up", mif.MemReq, 1);
    #2;
    rst_n = 1'b0;
    #1;
    m_ldata = '0;
    m_lsel  = '0;
    m_ltype = '0;
    check_eq("ar_req_drop", mif.MemReq, 0);
    check_eq("ar_stall_drop", StallReq, 0);
    check_w("ar");
    @(negedge clk);
    LoadTypeM = 3'd0;
    rst_n     = 1'b1;
    do_access(3'd1, 2'd0, 32'h0000_0010, 32'h0, 2, 32'h0BAD_F00D);

    do_access(3'd1, 2'd0, 32'h0000_4001, 32'h0, 0, 32'hA1B2_C3D4);
    do_access(3'd0, 2'd3, 32'h0000_4004, 32'h1234_5678, 0, 32'h0);

    for (int n = 0; n < 60; n++) begin
      lt = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) lt = 3'd0;
      r = int'($urandom_range(0, 19));
      dly = (r < 16) ? (r % 5) : (r < 18) ? TIMEOUT - 1 : NEVER;
      do_access(lt, 2'($urandom_range(0, 3)), $urandom, $urandom, dly, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
